// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared constants for the Pong match-flow sequencer: FSM state encodings,
// score/frame-counter widths and the winner codes driven on o_winner.
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam int SCORE_W     = 4;
   localparam int FRAME_CNT_W = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SERVE  = 3'd1;
   localparam logic [2:0] ST_PLAY   = 3'd2;
   localparam logic [2:0] ST_POINT  = 3'd3;
   localparam logic [2:0] ST_OVER   = 3'd4;
   localparam logic [2:0] ST_PAUSED = 3'd5;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Brings a raw asynchronous push-button into the i_clk domain through a
// two-flop synchronizer and emits a one-cycle pulse on each rising edge.
//
// Ports:
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   i_btn   - raw button level, asynchronous, active-high
//   o_pe    - one-cycle pulse per press
// ---------------------------------------------------------------------------
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pe
);

   logic sync_p0;
   logic sync_p1;
   logic prev_p2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
      end else begin
         // stage 0/1: metastability filter; stage 2: previous level for edge detect
         sync_p0 <= i_btn;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
      end
   end

   assign o_pe = sync_p1 & ~prev_p2;

endmodule

// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
// Match-flow sequencer for Pong: IDLE -> SERVE -> PLAY -> POINT/OVER, with
// an optional PAUSED state. Gates ball/paddle animation, re-serves the ball
// and owns the registered scores shown on the seven-segment display.
//
// Build option: define PONG_PAUSE_EN to enable the pause button and the
// PAUSED state; without it i_pause_btn is ignored.
//
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_animate               - one-cycle end-of-frame strobe
//   i_goal_p1, i_goal_p2    - goal levels from the ball (edge counted once)
//   i_start_btn, i_pause_btn- raw asynchronous buttons
//   o_play_en               - ball and paddles may animate
//   o_ball_reset            - one-cycle pulse on entry into SERVE
//   o_serve_dir             - 0 = toward player 1, 1 = toward player 2
//   o_score_p1, o_score_p2  - registered scores
//   o_winner                - 00 none, 01 player 1, 10 player 2
//   o_state                 - current FSM state encoding
// ---------------------------------------------------------------------------
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int OVER_FRAMES  = 255
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_animate,
   input  logic               i_goal_p1,
   input  logic               i_goal_p2,
   input  logic               i_start_btn,
   input  logic               i_pause_btn,
   output logic               o_play_en,
   output logic               o_ball_reset,
   output logic               o_serve_dir,
   output logic [SCORE_W-1:0] o_score_p1,
   output logic [SCORE_W-1:0] o_score_p2,
   output logic [1:0]         o_winner,
   output logic [2:0]         o_state
);

   localparam logic [SCORE_W-1:0]     WIN_SC   = SCORE_W'(WIN_SCORE);
   localparam logic [FRAME_CNT_W-1:0] SERVE_LD = FRAME_CNT_W'(SERVE_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] POINT_LD = FRAME_CNT_W'(POINT_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] OVER_LD  = FRAME_CNT_W'(OVER_FRAMES);

   logic                   start_pe;
   logic                   pause_pe;
   logic                   goal_p1_q;
   logic                   goal_p2_q;
   logic                   goal_p1_pe;
   logic                   goal_p2_pe;
   logic [2:0]             state_q;
   logic [2:0]             state_nxt;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic                   cnt_zero;
   logic                   expire;
   logic [SCORE_W-1:0]     s1_nxt;
   logic [SCORE_W-1:0]     s2_nxt;
   logic                   dir_nxt;
   logic [1:0]             win_nxt;

   btn_sync_edge u_start_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_start_btn),
      .o_pe    (start_pe)
   );

`ifdef PONG_PAUSE_EN
   btn_sync_edge u_pause_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_pause_btn),
      .o_pe    (pause_pe)
   );
`else
   logic unused_pause_btn;
   assign unused_pause_btn = i_pause_btn;
   assign pause_pe         = 1'b0;
`endif

   // Goals are already synchronous; only the rising edge counts.
   assign goal_p1_pe = i_goal_p1 & ~goal_p1_q;
   assign goal_p2_pe = i_goal_p2 & ~goal_p2_q;
   assign cnt_zero   = (frame_cnt == '0);
   assign expire     = cnt_zero & i_animate;
   assign o_state    = state_q;

   always_comb begin
      state_nxt = state_q;
      s1_nxt    = o_score_p1;
      s2_nxt    = o_score_p2;
      dir_nxt   = o_serve_dir;
      win_nxt   = o_winner;
      case (state_q)
         ST_IDLE: begin
            if (start_pe) begin
               state_nxt = ST_SERVE;
               s1_nxt    = '0;
               s2_nxt    = '0;
               win_nxt   = WIN_NONE;
            end
         end
         ST_SERVE: if (expire) state_nxt = ST_PLAY;
         ST_PLAY: begin
            // A goal outranks a pause press arriving in the same cycle.
            if (goal_p1_pe && goal_p2_pe) begin
               state_nxt = ST_POINT;
            end else if (goal_p1_pe) begin
               s1_nxt  = o_score_p1 + SCORE_W'(1);
               dir_nxt = 1'b1;
               if (s1_nxt == WIN_SC) begin
                  state_nxt = ST_OVER;
                  win_nxt   = WIN_P1;
               end else begin
                  state_nxt = ST_POINT;
               end
            end else if (goal_p2_pe) begin
               s2_nxt  = o_score_p2 + SCORE_W'(1);
               dir_nxt = 1'b0;
               if (s2_nxt == WIN_SC) begin
                  state_nxt = ST_OVER;
                  win_nxt   = WIN_P2;
               end else begin
                  state_nxt = ST_POINT;
               end
            end else if (pause_pe) begin
               state_nxt = ST_PAUSED;
            end
         end
         ST_POINT: if (expire) state_nxt = ST_SERVE;
         ST_OVER: begin
            if (cnt_zero && start_pe) begin
               state_nxt = ST_SERVE;
               s1_nxt    = '0;
               s2_nxt    = '0;
               win_nxt   = WIN_NONE;
            end
         end
         ST_PAUSED: if (pause_pe) state_nxt = ST_PLAY;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         o_score_p1   <= '0;
         o_score_p2   <= '0;
         o_serve_dir  <= 1'b0;
         o_winner     <= WIN_NONE;
         o_play_en    <= 1'b0;
         o_ball_reset <= 1'b0;
         frame_cnt    <= '0;
         goal_p1_q    <= 1'b0;
         goal_p2_q    <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         o_score_p1   <= s1_nxt;
         o_score_p2   <= s2_nxt;
         o_serve_dir  <= dir_nxt;
         o_winner     <= win_nxt;
         goal_p1_q    <= i_goal_p1;
         goal_p2_q    <= i_goal_p2;
         o_play_en    <= (state_nxt == ST_PLAY);
         o_ball_reset <= (state_nxt == ST_SERVE) && (state_q != ST_SERVE);
         // Load on entry; otherwise count frames down, frozen while paused.
         if (state_nxt != state_q) begin
            case (state_nxt)
               ST_SERVE: frame_cnt <= SERVE_LD;
               ST_POINT: frame_cnt <= POINT_LD;
               ST_OVER:  frame_cnt <= OVER_LD;
               default:  frame_cnt <= frame_cnt;
            endcase
         end else if (i_animate && !cnt_zero && state_q != ST_PAUSED) begin
            frame_cnt <= frame_cnt - FRAME_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

   localparam int WIN   = 7;
   localparam int SERVE = 60;
   localparam int POINT = 90;
   localparam int OVER  = 255;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SERVE  = 3'd1;
   localparam logic [2:0] S_PLAY   = 3'd2;
   localparam logic [2:0] S_POINT  = 3'd3;
   localparam logic [2:0] S_OVER   = 3'd4;
   localparam logic [2:0] S_PAUSED = 3'd5;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_animate;
   logic       i_goal_p1;
   logic       i_goal_p2;
   logic       i_start_btn;
   logic       i_pause_btn;
   logic       o_play_en;
   logic       o_ball_reset;
   logic       o_serve_dir;
   logic [3:0] o_score_p1;
   logic [3:0] o_score_p2;
   logic [1:0] o_winner;
   logic [2:0] o_state;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model of the match
   logic [3:0] m_s1;
   logic [3:0] m_s2;
   logic       m_dir;
   logic [1:0] m_win;

   pong_match_ctrl #(
      .WIN_SCORE    (WIN),
      .SERVE_FRAMES (SERVE),
      .POINT_FRAMES (POINT),
      .OVER_FRAMES  (OVER)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_animate    (i_animate),
      .i_goal_p1    (i_goal_p1),
      .i_goal_p2    (i_goal_p2),
      .i_start_btn  (i_start_btn),
      .i_pause_btn  (i_pause_btn),
      .o_play_en    (o_play_en),
      .o_ball_reset (o_ball_reset),
      .o_serve_dir  (o_serve_dir),
      .o_score_p1   (o_score_p1),
      .o_score_p2   (o_score_p2),
      .o_winner     (o_winner),
      .o_state      (o_state)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: sim time exceeded, state %0d", o_state);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One end-of-frame strobe; outputs sampled just after the edge that sees it.
   task automatic strobe(output logic br, output logic [2:0] st, output logic pe);
      i_animate = 1'b1;
      tick();
      br = o_ball_reset;
      st = o_state;
      pe = o_play_en;
      i_animate = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic run_frames(input int n, input logic [2:0] exp_st, input string nm);
      logic br, pe;
      logic [2:0] st;
      int resets = 0;
      st = o_state;
      for (int i = 0; i < n; i++) begin
         strobe(br, st, pe);
         if (br) resets++;
      end
      n_cmp++;
      if (st !== exp_st) begin
         n_bad++;
         $display("FAIL %s_state: got %0d want %0d after %0d frames", nm, st, exp_st, n);
      end
      n_cmp++;
      if (resets !== 0) begin
         n_bad++;
         $display("FAIL %s_noreset: got %0d ball_reset pulses want 0", nm, resets);
      end
   endtask

   task automatic serve_to_play();
      logic br, pe;
      logic [2:0] st;
      run_frames(SERVE, S_SERVE, "serve_hold");
      strobe(br, st, pe);
      n_cmp++;
      if (st !== S_PLAY || pe !== 1'b1) begin
         n_bad++;
         $display("FAIL serve_expire: got state %0d play_en %0b want %0d/1", st, pe, S_PLAY);
      end
   endtask

   task automatic point_to_serve();
      logic br, pe;
      logic [2:0] st;
      run_frames(POINT, S_POINT, "point_hold");
      strobe(br, st, pe);
      n_cmp++;
      if (st !== S_SERVE || br !== 1'b1) begin
         n_bad++;
         $display("FAIL point_expire: got state %0d ball_reset %0b want %0d/1", st, br, S_SERVE);
      end
      tick();
      n_cmp++;
      if (o_ball_reset !== 1'b0) begin
         n_bad++;
         $display("FAIL point_pulse_width: got ball_reset %0b want 0", o_ball_reset);
      end
   endtask

   // Press start and expect the match to (re)start with a ball_reset pulse.
   task automatic press_start_expect();
      logic found = 1'b0;
      logic [2:0] st = '0;
      logic [3:0] s1 = '1, s2 = '1;
      logic [1:0] w = '1;
      i_start_btn = 1'b1;
      for (int i = 0; i < 16 && !found; i++) begin
         tick();
         if (i == 4) i_start_btn = 1'b0;
         if (o_ball_reset === 1'b1) begin
            found = 1'b1;
            st = o_state; s1 = o_score_p1; s2 = o_score_p2; w = o_winner;
         end
      end
      i_start_btn = 1'b0;
      m_s1 = '0; m_s2 = '0; m_win = 2'b00;
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL start_pulse: no ball_reset within 16 cycles, want 1");
      end
      n_cmp++;
      if (st !== S_SERVE || s1 !== m_s1 || s2 !== m_s2 || w !== m_win) begin
         n_bad++;
         $display("FAIL start_clear: got st %0d sc %0d/%0d win %0d want %0d 0/0 0", st, s1, s2, w, S_SERVE);
      end
      tick();
      n_cmp++;
      if (o_ball_reset !== 1'b0 || o_play_en !== 1'b0) begin
         n_bad++;
         $display("FAIL start_pulse_width: got ball_reset %0b play_en %0b want 0/0", o_ball_reset, o_play_en);
      end
      repeat (6) tick();
   endtask

   // Score one goal from PLAY; continue back into PLAY unless the match ends.
   task automatic score_goal(input int p, input int hold_in);
      int hold;
      logic over;
      hold = (hold_in > 0) ? hold_in : $urandom_range(1, 30);
      if (p == 1) begin m_s1 = m_s1 + 4'd1; m_dir = 1'b1; i_goal_p1 = 1'b1; end
      else        begin m_s2 = m_s2 + 4'd1; m_dir = 1'b0; i_goal_p2 = 1'b1; end
      over = (int'(m_s1) == WIN) || (int'(m_s2) == WIN);
      if (over) m_win = (p == 1) ? 2'b01 : 2'b10;
      repeat (hold) tick();
      i_goal_p1 = 1'b0;
      i_goal_p2 = 1'b0;
      tick();
      n_cmp++;
      if (o_score_p1 !== m_s1 || o_score_p2 !== m_s2) begin
         n_bad++;
         $display("FAIL goal_score: got %0d/%0d want %0d/%0d", o_score_p1, o_score_p2, m_s1, m_s2);
      end
      n_cmp++;
      if (o_serve_dir !== m_dir || o_winner !== m_win || o_play_en !== 1'b0) begin
         n_bad++;
         $display("FAIL goal_flags: got dir %0b win %0d play_en %0b want %0b %0d 0",
                  o_serve_dir, o_winner, o_play_en, m_dir, m_win);
      end
      n_cmp++;
      if (o_state !== (over ? S_OVER : S_POINT)) begin
         n_bad++;
         $display("FAIL goal_state: got %0d want %0d", o_state, over ? S_OVER : S_POINT);
      end
      if (!over) begin
         point_to_serve();
         serve_to_play();
      end
   endtask

   task automatic play_list(input int n1, input int n2);
      int lst[16];
      int n, j, t;
      n = n1 + n2;
      for (int i = 0; i < n; i++) lst[i] = (i < n1) ? 1 : 2;
      for (int i = n - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = lst[i]; lst[i] = lst[j]; lst[j] = t;
      end
      for (int i = 0; i < n; i++) score_goal(lst[i], 0);
   endtask

   task automatic test_reset();
      n_cmp++;
      if (o_state !== S_IDLE || o_play_en !== 1'b0 || o_ball_reset !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got st %0d play %0b br %0b want 0 0 0", o_state, o_play_en, o_ball_reset);
      end
      n_cmp++;
      if (o_score_p1 !== 4'd0 || o_score_p2 !== 4'd0 || o_winner !== 2'b00 || o_serve_dir !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_data: got sc %0d/%0d win %0d dir %0b want 0/0 0 0",
                  o_score_p1, o_score_p2, o_winner, o_serve_dir);
      end
   endtask

   task automatic test_serve_timing();
      press_start_expect();
      serve_to_play();
   endtask

   task automatic test_goal_hold();
      score_goal(1, 500);
   endtask

   task automatic test_simultaneous();
      play_list(1, 2);
      i_goal_p1 = 1'b1;
      i_goal_p2 = 1'b1;
      repeat ($urandom_range(1, 20)) tick();
      i_goal_p1 = 1'b0;
      i_goal_p2 = 1'b0;
      tick();
      n_cmp++;
      if (o_score_p1 !== 4'd2 || o_score_p2 !== 4'd2 || o_serve_dir !== m_dir) begin
         n_bad++;
         $display("FAIL simul_score: got %0d/%0d dir %0b want 2/2 dir %0b", o_score_p1, o_score_p2, o_serve_dir, m_dir);
      end
      n_cmp++;
      if (o_state !== S_POINT) begin
         n_bad++;
         $display("FAIL simul_state: got %0d want %0d", o_state, S_POINT);
      end
      point_to_serve();
      serve_to_play();
   endtask

   task automatic test_match_end();
      int n1;
      play_list($urandom_range(0, 2), 4);
      score_goal(2, 0);
      // goal edge during OVER must not count
      i_goal_p1 = 1'b1;
      repeat (3) tick();
      i_goal_p1 = 1'b0;
      tick();
      n_cmp++;
      if (o_state !== S_OVER || o_score_p1 !== m_s1 || o_score_p2 !== 4'd7 || o_winner !== 2'b10) begin
         n_bad++;
         $display("FAIL over_hold: got st %0d sc %0d/%0d win %0d want %0d %0d/7 2",
                  o_state, o_score_p1, o_score_p2, o_winner, S_OVER, m_s1);
      end
      n1 = $urandom_range(50, 200);
      run_frames(n1, S_OVER, "over_early");
      i_start_btn = 1'b1;
      repeat (5) tick();
      i_start_btn = 1'b0;
      repeat (5) tick();
      n_cmp++;
      if (o_state !== S_OVER || o_score_p2 !== 4'd7 || o_winner !== 2'b10 || o_ball_reset !== 1'b0) begin
         n_bad++;
         $display("FAIL over_early_start: got st %0d sc2 %0d win %0d want %0d 7 2", o_state, o_score_p2, o_winner, S_OVER);
      end
      run_frames(OVER - n1, S_OVER, "over_late");
      press_start_expect();
      serve_to_play();
   endtask

   task automatic test_reset_midmatch();
      int cnt = 0;
      play_list(3, 2);
      i_rst_n = 1'b0;
      #2;
      n_cmp++;
      if (o_state !== S_IDLE || o_score_p1 !== 4'd0 || o_score_p2 !== 4'd0 || o_play_en !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got st %0d sc %0d/%0d play %0b want 0 0/0 0",
                  o_state, o_score_p1, o_score_p2, o_play_en);
      end
      repeat (3) tick();
      #3 i_rst_n = 1'b1;
      m_s1 = '0; m_s2 = '0; m_dir = 1'b0; m_win = 2'b00;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (o_ball_reset !== 1'b0 || o_state !== S_IDLE) cnt++;
      end
      n_cmp++;
      if (cnt !== 0) begin
         n_bad++;
         $display("FAIL reset_release: got %0d bad cycles want 0", cnt);
      end
   endtask

`ifdef PONG_PAUSE_EN
   task automatic wait_state(input logic [2:0] want, input string nm);
      logic ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         tick();
         if (i == 4) i_pause_btn = 1'b0;
         if (o_state === want) ok = 1'b1;
      end
      i_pause_btn = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got state %0d want %0d", nm, o_state, want);
      end
      repeat (6) tick();
   endtask

   task automatic test_pause();
      press_start_expect();
      serve_to_play();
      play_list(1, 1);
      i_pause_btn = 1'b1;
      wait_state(S_PAUSED, "pause_enter");
      i_goal_p2 = 1'b1;
      repeat (4) tick();
      i_goal_p2 = 1'b0;
      tick();
      n_cmp++;
      if (o_state !== S_PAUSED || o_play_en !== 1'b0 || o_score_p2 !== m_s2) begin
         n_bad++;
         $display("FAIL pause_goal: got st %0d play %0b sc2 %0d want %0d 0 %0d", o_state, o_play_en, o_score_p2, S_PAUSED, m_s2);
      end
      i_pause_btn = 1'b1;
      wait_state(S_PLAY, "pause_exit");
      n_cmp++;
      if (o_play_en !== 1'b1 || o_score_p1 !== m_s1 || o_score_p2 !== m_s2) begin
         n_bad++;
         $display("FAIL pause_resume: got play %0b sc %0d/%0d want 1 %0d/%0d", o_play_en, o_score_p1, o_score_p2, m_s1, m_s2);
      end
   endtask
`endif

   initial begin
      i_rst_n     = 1'b0;
      i_animate   = 1'b0;
      i_goal_p1   = 1'b0;
      i_goal_p2   = 1'b0;
      i_start_btn = 1'b0;
      i_pause_btn = 1'b0;
      m_s1 = '0; m_s2 = '0; m_dir = 1'b0; m_win = 2'b00;
      repeat (3) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      tick();
      test_reset();
      test_serve_timing();
      test_goal_hold();
      test_simultaneous();
      test_match_end();
      test_reset_midmatch();
`ifdef PONG_PAUSE_EN
      test_pause();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
